// File: rtl/mem_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the two-port memory arbiter  |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// +--------------------------------------------------------------------------+
// | mem_arb_pick : combinational winner selection between two requesters      |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_idx_o
);

  always_comb begin
    grant_valid_o = req0_i | req1_i;
    grant_idx_o   = PORT0;
    // On a tie the port that did not win last time is chosen.
    if (req0_i && req1_i) begin
      grant_idx_o = ~last_grant_i;
    end else if (req1_i) begin
      grant_idx_o = PORT1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | mem_port_arbiter : two-requester single-port memory arbiter, 3-cycle ops  |
// | Option: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.       |
// | Revision         : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              sigMemRead,
  output logic              sigMemWrite,
  output logic [ADDR_W-1:0] dataAddress,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                grant_valid;
  logic                grant_idx;
  logic                pick_last;
  logic                grant_take;

  assign grant_take = (state_q == IDLE) && grant_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= PORT1;
    end else if (grant_take) begin
      last_grant_q <= grant_idx;
    end
  end

  assign pick_last = last_grant_q;
`else
  // Pretending port 1 always won last makes every tie go to port 0.
  assign pick_last = PORT1;
`endif

  mem_arb_pick u_pick (
    .req0_i        (req0),
    .req1_i        (req1),
    .last_grant_i  (pick_last),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= PORT0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (grant_take) begin
        owner_q <= grant_idx;
        we_q    <= (grant_idx == PORT0) ? we0    : we1;
        addr_q  <= (grant_idx == PORT0) ? addr0  : addr1;
        wdata_q <= (grant_idx == PORT0) ? wdata0 : wdata1;
      end
      if ((state_q == ACCESS) && !we_q) begin
        if (owner_q == PORT0) begin
          rdata0_q <= readData;
        end else begin
          rdata1_q <= readData;
        end
      end
    end
  end

  assign sigMemRead  = (state_q == ACCESS) && !we_q;
  assign sigMemWrite = (state_q == ACCESS) &&  we_q;
  assign dataAddress = addr_q;
  assign writeData   = wdata_q;
  assign ack0        = (state_q == ACK) && (owner_q == PORT0);
  assign ack1        = (state_q == ACK) && (owner_q == PORT1);
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter : self-checking bench for mem_port_arbiter            |
// | Revision            : 1.0                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, sigMemRead, sigMemWrite, busy;
  logic [7:0] rdata0, rdata1, dataAddress, writeData, readData;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rdata [2];
  int         exp_last;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack0        (ack0),
    .ack1        (ack1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .sigMemRead  (sigMemRead),
    .sigMemWrite (sigMemWrite),
    .dataAddress (dataAddress),
    .writeData   (writeData),
    .readData    (readData),
    .busy        (busy)
  );

  // External memory: combinational read, write on the clock edge.
  assign readData = mem[dataAddress];
  always @(posedge clk) if (sigMemWrite === 1'b1) mem[dataAddress] <= writeData;

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if ((sigMemRead === 1'b1 && sigMemWrite === 1'b1) || (ack0 === 1'b1 && ack1 === 1'b1)) begin
        $display("FAIL exclusivity rd=%b wr=%b ack0=%b ack1=%b required never both high",
                 sigMemRead, sigMemWrite, ack0, ack1);
        miscompares++;
      end
    end
  end

  // Arbitration rule: lone requester wins; ties go by configuration.
  function automatic int pick_winner(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return 1 - exp_last;
`else
      return 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  task automatic new_req(input int p);
    logic       w;
    logic [7:0] a, d;
    w = 1'($urandom_range(0, 1));
    a = 8'($urandom_range(0, 15));
    d = 8'($urandom);
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_last = 1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, sigMemRead, sigMemWrite, busy} !== 5'b0) begin
      $display("FAIL reset_ctrl got %b required 00000", {ack0, ack1, sigMemRead, sigMemWrite, busy});
      miscompares++;
    end
    vectors++;
    if ({rdata0, rdata1, dataAddress, writeData} !== 32'h0) begin
      $display("FAIL reset_data got %h required 00000000", {rdata0, rdata1, dataAddress, writeData});
      miscompares++;
    end
    reset = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_last = 1;
    chk_en = 1'b1;
  endtask

  task automatic test_write_read;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
    @(negedge clk);
    vectors++;
    if ({sigMemWrite, sigMemRead, busy, ack0, dataAddress, writeData} !== {4'b1010, 8'h10, 8'hA5}) begin
      $display("FAIL wr_access got %b/%h/%h required 1010/10/a5",
               {sigMemWrite, sigMemRead, busy, ack0}, dataAddress, writeData);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, sigMemWrite} !== 3'b100) begin
      $display("FAIL wr_ack got %b required 100", {ack0, ack1, sigMemWrite});
      miscompares++;
    end
    req0 = 1'b0; ref_mem[8'h10] = 8'hA5;
    @(negedge clk);
    vectors++;
    if ({busy, sigMemWrite, dataAddress} !== {2'b00, 8'h10}) begin
      $display("FAIL wr_idle got %b/%h required 00/10", {busy, sigMemWrite}, dataAddress);
      miscompares++;
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10; wdata1 = 8'h00;
    @(negedge clk);
    vectors++;
    if ({sigMemRead, sigMemWrite, dataAddress} !== {2'b10, 8'h10}) begin
      $display("FAIL rd_access got %b/%h required 10/10", {sigMemRead, sigMemWrite}, dataAddress);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, rdata1, rdata0} !== {2'b01, 8'hA5, 8'h00}) begin
      $display("FAIL rd_ack got %b/%h/%h required 01/a5/00", {ack0, ack1}, rdata1, rdata0);
      miscompares++;
    end
    req1 = 1'b0; exp_rdata[1] = 8'hA5; exp_last = 1;
    @(negedge clk);
  endtask

  task automatic test_late_req;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, rdata0} !== {2'b10, 8'hA5}) begin
      $display("FAIL late_ack0 got %b/%h required 10/a5", {ack0, ack1}, rdata0);
      miscompares++;
    end
    exp_rdata[0] = 8'hA5;
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h33; wdata1 = 8'h5C;
    @(negedge clk);
    vectors++;
    if ({busy, sigMemWrite, ack0, ack1} !== 4'b0000) begin
      $display("FAIL late_idle got %b required 0000", {busy, sigMemWrite, ack0, ack1});
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({sigMemWrite, dataAddress, writeData} !== {1'b1, 8'h33, 8'h5C}) begin
      $display("FAIL late_access got %b/%h/%h required 1/33/5c", sigMemWrite, dataAddress, writeData);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({ack0, ack1} !== 2'b01) begin
      $display("FAIL late_ack1 got %b required 01", {ack0, ack1});
      miscompares++;
    end
    req1 = 1'b0; ref_mem[8'h33] = 8'h5C; exp_last = 1;
    @(negedge clk);
  endtask

  task automatic test_reset_during_access;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h77;
    @(negedge clk);
    vectors++;
    if ({sigMemWrite, dataAddress} !== {1'b1, 8'h20}) begin
      $display("FAIL rst_pre got %b/%h required 1/20", sigMemWrite, dataAddress);
      miscompares++;
    end
    reset = 1'b1; req0 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, sigMemRead, sigMemWrite, busy, rdata0, rdata1} !== {5'b0, 16'h0}) begin
      $display("FAIL rst_abort got %b/%h/%h required 00000/00/00",
               {ack0, ack1, sigMemRead, sigMemWrite, busy}, rdata0, rdata1);
      miscompares++;
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, busy} !== 3'b000) begin
      $display("FAIL rst_noack got %b required 000", {ack0, ack1, busy});
      miscompares++;
    end
    // That write may or may not have landed; either outcome is legal.
    ref_mem[8'h20] = mem[8'h20];
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_last = 1;
  endtask

  task automatic test_back_to_back;
    int         exp_order [4];
    int         got;
    int         w;
    logic       we;
    logic [7:0] a, d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    do_reset();
    new_req(0); new_req(1);
    for (int k = 0; k < 4; k++) begin
      w  = exp_order[k];
      we = (w == 0) ? we0 : we1;
      a  = (w == 0) ? addr0 : addr1;
      d  = (w == 0) ? wdata0 : wdata1;
      @(negedge clk);
      vectors++;
      if ({sigMemWrite, sigMemRead, dataAddress} !== {we, !we, a}) begin
        $display("FAIL b2b_access[%0d] got %b/%h required %b/%h", k,
                 {sigMemWrite, sigMemRead}, dataAddress, {we, !we}, a);
        miscompares++;
      end
      @(negedge clk);
      got = (ack1 === 1'b1) ? 1 : 0;
      vectors++;
      if ((ack0 ^ ack1) !== 1'b1 || got != w) begin
        $display("FAIL b2b_order[%0d] got ack0=%b ack1=%b required port %0d", k, ack0, ack1, w);
        miscompares++;
      end
      if (we) ref_mem[a] = d; else exp_rdata[w] = ref_mem[a];
      vectors++;
      if ({rdata0, rdata1} !== {exp_rdata[0], exp_rdata[1]}) begin
        $display("FAIL b2b_rdata[%0d] got %h/%h required %h/%h", k, rdata0, rdata1, exp_rdata[0], exp_rdata[1]);
        miscompares++;
      end
      exp_last = w;
      new_req(w);
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    int         w;
    logic       we;
    logic [7:0] a, d;
    for (int n = 0; n < 60; n++) begin
      if (!req0 && !req1) begin
        if ($urandom_range(0, 2) != 0) new_req(0);
        if (!req0 || $urandom_range(0, 1) == 1) new_req(1);
      end
      w  = pick_winner(req0, req1);
      we = (w == 0) ? we0 : we1;
      a  = (w == 0) ? addr0 : addr1;
      d  = (w == 0) ? wdata0 : wdata1;
      @(negedge clk);
      vectors++;
      if ({sigMemRead, sigMemWrite, dataAddress, writeData, busy} !== {!we, we, a, d, 1'b1}) begin
        $display("FAIL rnd_access[%0d] got %b/%h/%h required %b/%h/%h", n,
                 {sigMemRead, sigMemWrite}, dataAddress, writeData, {!we, we}, a, d);
        miscompares++;
      end
      @(negedge clk);
      if (we) ref_mem[a] = d; else exp_rdata[w] = ref_mem[a];
      vectors++;
      if ({ack0, ack1, rdata0, rdata1} !== {w == 0, w == 1, exp_rdata[0], exp_rdata[1]}) begin
        $display("FAIL rnd_ack[%0d] got %b/%h/%h required port %0d %h/%h", n,
                 {ack0, ack1}, rdata0, rdata1, w, exp_rdata[0], exp_rdata[1]);
        miscompares++;
      end
      exp_last = w;
      if ($urandom_range(0, 1) == 1) new_req(w);
      else if (w == 0) req0 = 1'b0;
      else req1 = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, ack0, ack1, rdata0, rdata1} !== {3'b000, exp_rdata[0], exp_rdata[1]}) begin
        $display("FAIL rnd_idle[%0d] got %b/%h/%h required 000/%h/%h", n,
                 {busy, ack0, ack1}, rdata0, rdata1, exp_rdata[0], exp_rdata[1]);
        miscompares++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_last = 1;
    test_reset();
    test_write_read();
    test_late_req();
    test_reset_during_access();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
